// File: rtl/scan_sequencer_if.sv
// Control and decoder-drive bundle between a scan controller (master) and the scan_sequencer (slave).
// The master drives mode/step/load/blank; the slave returns the registered decoder drive and wrap pulse.
interface scan_sequencer_if;
   logic       run;
   logic       dir;
   logic       bounce;
   logic       step;
   logic       load;
   logic [2:0] load_val;
   logic       blank;
   logic       e;
   logic       a;
   logic       b;
   logic       c;
   logic       wrap;

   modport master (
      output run, dir, bounce, step, load, load_val, blank,
      input  e, a, b, c, wrap
   );

   modport slave (
      input  run, dir, bounce, step, load, load_val, blank,
      output e, a, b, c, wrap
   );
endinterface

// File: rtl/scan_sequencer.sv
// Sequential front end for a 3-to-8 decoder: steps a 3-bit index up/down/ping-pong from a
// prescaler or a single-step edge, with synchronous load and registered enable blanking.
//
// Direction state:
//   state    | meaning
//   DIR_UP   | next advance increments idx (ping-pong turns around at 7)
//   DIR_DOWN | next advance decrements idx (ping-pong turns around at 0)
module scan_sequencer #(
   parameter int unsigned DIV = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   scan_sequencer_if.slave   bus
);

   localparam int unsigned   CW      = (DIV <= 2) ? 1 : $clog2(DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   dir_e          dirst_q, dirst_d;
   logic [2:0]    idx_q,   idx_d;
   logic [CW-1:0] cnt_q,   cnt_d;
   logic          step_q;
   logic          e_q,     e_d;
   logic          wrap_q,  wrap_d;
   logic          tick;
   logic          srise;
   logic          adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dirst_q <= DIR_UP;
         idx_q   <= 3'd0;
         cnt_q   <= '0;
         step_q  <= 1'b0;
         e_q     <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         dirst_q <= dirst_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         step_q  <= bus.step;
         e_q     <= e_d;
         wrap_q  <= wrap_d;
      end
   end

   always_comb begin
      dirst_d = dirst_q;
      idx_d   = idx_q;
      cnt_d   = '0;
      wrap_d  = 1'b0;
      e_d     = ~bus.blank;
      tick    = 1'b0;

      // Halting clears the count so a later run always starts a full period.
      if (bus.run) begin
         tick  = (cnt_q == CNT_MAX);
         cnt_d = tick ? '0 : cnt_q + CW'(1);
      end

      srise = bus.step & ~step_q;
      adv   = tick | (srise & ~bus.run);

      if (bus.load) begin
         idx_d   = bus.load_val;
         cnt_d   = '0;
         dirst_d = dir_e'(bus.dir);
      end else if (!bus.bounce) begin
         dirst_d = dir_e'(bus.dir);
         if (adv) begin
            if (bus.dir == 1'b0) begin
               idx_d  = idx_q + 3'd1;
               wrap_d = (idx_q == 3'd7);
            end else begin
               idx_d  = idx_q - 3'd1;
               wrap_d = (idx_q == 3'd0);
            end
         end
      end else if (adv) begin
         unique case (dirst_q)
            DIR_UP: begin
               if (idx_q == 3'd7) begin
                  idx_d   = 3'd6;
                  dirst_d = DIR_DOWN;
                  wrap_d  = 1'b1;
               end else begin
                  idx_d   = idx_q + 3'd1;
               end
            end
            DIR_DOWN: begin
               if (idx_q == 3'd0) begin
                  idx_d   = 3'd1;
                  dirst_d = DIR_UP;
                  wrap_d  = 1'b1;
               end else begin
                  idx_d   = idx_q - 3'd1;
               end
            end
            default: begin
               dirst_d = DIR_UP;
            end
         endcase
      end
   end

   assign bus.e    = e_q;
   assign bus.a    = idx_q[2];
   assign bus.b    = idx_q[1];
   assign bus.c    = idx_q[0];
   assign bus.wrap = wrap_q;

endmodule
